compl_req_arbiter: RTL and testbench
====================================

Name: compl_req_arbiter

Overview:
- Shares the single TX completion engine (req_compl/compl_done handshake plus TLP header fields) between two requesters.
- Requester A is the command-processing FSM fed by the upstream command FIFO; requester B is a secondary completer, e.g. the register/status responder.
- Round-robin grant, header latching, and a completion-done watchdog with sticky error flags.

Parameters:
TIMEOUT_CYCLES, 1024, max cycles BUSY waits for compl_done_i before forced release; 0 disables the watchdog
CNT_W, 16, width of the watchdog counter and timeout_cnt_o

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
a_req_i  input  1  requester A wants a completion; held until a_done_o
a_with_data_i  input  1  A's completion carries data (CplD)
a_hdr_i  input  56  A's header: [55:53] tc, [52] td, [51] ep, [50:49] attr, [48:39] len, [38:23] rid, [22:15] tag, [14:7] be, [6:0] addr
a_done_o  output  1  1-cycle pulse, A's completion finished or aborted
b_req_i, b_with_data_i, b_hdr_i, b_done_o  same as A, for requester B
req_compl_o  output  1  to TX engine, level request
req_compl_with_data_o  output  1  to TX engine
compl_done_i  input  1  TX engine completion done, 1-cycle pulse
req_tc_o 3, req_td_o 1, req_ep_o 1, req_attr_o 2, req_len_o 10, req_rid_o 16, req_tag_o 8, req_be_o 8, req_addr_o 7  outputs  latched header fields of the granted requester
grant_b_o  output  1  current/last grant owner (0=A, 1=B)
err_timeout_o  output  1  sticky: watchdog fired
err_spurious_o  output  1  sticky: compl_done_i outside BUSY
timeout_cnt_o  output  CNT_W  count of watchdog events, saturating
clr_err_i  input  1  clears both sticky flags and timeout_cnt_o

Behaviour:
- States: IDLE, BUSY, RELEASE.
- Reset values:
  - state=IDLE; all outputs 0.
  - last-grant pointer = B, so A wins the first tie.
- IDLE:
  - If exactly one req_i is high, grant it.
  - If both are high, grant the one not last granted.
  - On grant, at the next edge: go BUSY; req_compl_o=1; latch with_data and hdr into the req_* outputs; update the pointer and grant_b_o; clear the watchdog.
- Latency: req_i sampled high in IDLE at edge N, so req_compl_o is high after edge N.
- BUSY:
  - req_compl_o and the fields stay stable; requester inputs are ignored.
  - The watchdog increments every cycle.
  - On compl_done_i=1: go RELEASE, req_compl_o=0, done_o pulse for the owner.
  - Else, if TIMEOUT_CYCLES≠0 and the watchdog reaches TIMEOUT_CYCLES-1: same transition, plus err_timeout_o=1 and timeout_cnt_o+1 (saturates at all-ones).
  - compl_done_i in the same cycle as watchdog expiry: the completion wins, no error.
- RELEASE:
  - Lasts exactly one cycle; done_o is high during this cycle only.
  - The owner must drop req_i at the edge ending RELEASE; then go IDLE.
  - Back-to-back grant: the next req_compl_o rises two cycles after RELEASE begins.
- req_* fields hold their last value while not BUSY; req_compl_with_data_o clears with req_compl_o.
- Spurious done: compl_done_i=1 in IDLE or RELEASE is ignored for the FSM and sets err_spurious_o.
- clr_err_i:
  - Clears both flags and timeout_cnt_o at the next edge.
  - If it coincides with a new error event, the error wins: flag=1 and count=1.
- rst during BUSY:
  - Abort immediately: IDLE, req_compl_o=0, no done_o.
  - The TX engine is reset together with the arbiter.

Test Plan:
- A only, hdr tc=0 len=1 tag=0x05 be=0x0F, with_data=1; compl_done_i 5 cycles later → req_compl_o high 1 cycle after req and held; fields match; a_done_o single pulse 1 cycle after done; b_done_o never.
- A and B request in the same cycle after reset, B kept asserted → order A, B, A, B; grant_b_o toggles each grant; two cycles between a done and the next req_compl_o.
- TIMEOUT_CYCLES=16, compl_done_i never arrives → forced release after 16 BUSY cycles; err_timeout_o=1; timeout_cnt_o=1; owner done pulse; the next requester is then served normally.
- compl_done_i on the exact watchdog expiry cycle → normal release; err_timeout_o=0; timeout_cnt_o unchanged.
- compl_done_i pulsed in IDLE → err_spurious_o=1, state stays IDLE; then clr_err_i → both flags 0 and count 0.
- rst asserted mid-BUSY for 1 cycle → req_compl_o=0 the next cycle, no done pulse; after release of rst, with A and B pending, A is granted first.

Source files
------------

// File: rtl/compl_req_arbiter.sv
// Round-robin sharing of the single TX completion engine between two requesters,
// with header latching, a completion-done watchdog and sticky error reporting.
module compl_req_arbiter #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_req_i,
  input  logic             a_with_data_i,
  input  logic [55:0]      a_hdr_i,
  output logic             a_done_o,
  input  logic             b_req_i,
  input  logic             b_with_data_i,
  input  logic [55:0]      b_hdr_i,
  output logic             b_done_o,
  output logic             req_compl_o,
  output logic             req_compl_with_data_o,
  input  logic             compl_done_i,
  output logic [2:0]       req_tc_o,
  output logic             req_td_o,
  output logic             req_ep_o,
  output logic [1:0]       req_attr_o,
  output logic [9:0]       req_len_o,
  output logic [15:0]      req_rid_o,
  output logic [7:0]       req_tag_o,
  output logic [7:0]       req_be_o,
  output logic [6:0]       req_addr_o,
  output logic             grant_b_o,
  output logic             err_timeout_o,
  output logic             err_spurious_o,
  output logic [CNT_W-1:0] timeout_cnt_o,
  input  logic             clr_err_i
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  typedef struct packed {
    logic [2:0]  tc;
    logic        td;
    logic        ep;
    logic [1:0]  attr;
    logic [9:0]  len;
    logic [15:0] rid;
    logic [7:0]  tag;
    logic [7:0]  be;
    logic [6:0]  addr;
  } hdr_t;

  localparam bit             WD_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] WD_LAST = (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state;
  logic             last_b;
  logic [CNT_W-1:0] wd;
  hdr_t             hdr_lat;

  logic             grant_any;
  logic             pick_b;
  logic             sel_with_data;
  hdr_t             sel_hdr;
  logic             wd_expire;
  logic             timeout_evt;
  logic             spurious_evt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      sat_inc = v;
    end else begin
      sat_inc = v + CNT_W'(1);
    end
  endfunction

  // Arbitration pick and error-event decode
  always_comb begin
    grant_any     = a_req_i | b_req_i;
    pick_b        = b_req_i & (~a_req_i | ~last_b);
    sel_with_data = 1'b0;
    sel_hdr       = '0;
    if (pick_b) begin
      sel_with_data = b_with_data_i;
      sel_hdr       = hdr_t'(b_hdr_i);
    end else begin
      sel_with_data = a_with_data_i;
      sel_hdr       = hdr_t'(a_hdr_i);
    end
    wd_expire    = WD_EN && (wd == WD_LAST);
    // A completion landing on the expiry cycle takes precedence over the watchdog.
    timeout_evt  = (state == BUSY) && !compl_done_i && wd_expire;
    spurious_evt = compl_done_i && (state != BUSY);
  end

  // Grant FSM, header latch, watchdog and sticky error bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      state                 <= IDLE;
      last_b                <= 1'b1;
      wd                    <= '0;
      hdr_lat               <= '0;
      req_compl_o           <= 1'b0;
      req_compl_with_data_o <= 1'b0;
      grant_b_o             <= 1'b0;
      a_done_o              <= 1'b0;
      b_done_o              <= 1'b0;
      err_timeout_o         <= 1'b0;
      err_spurious_o        <= 1'b0;
      timeout_cnt_o         <= '0;
    end else begin
      case (state)
        IDLE: begin
          a_done_o <= 1'b0;
          b_done_o <= 1'b0;
          if (grant_any) begin
            state                 <= BUSY;
            req_compl_o           <= 1'b1;
            req_compl_with_data_o <= sel_with_data;
            hdr_lat               <= sel_hdr;
            grant_b_o             <= pick_b;
            last_b                <= pick_b;
            wd                    <= '0;
          end else begin
            state <= IDLE;
          end
        end
        BUSY: begin
          if (compl_done_i || wd_expire) begin
            state                 <= RELEASE;
            req_compl_o           <= 1'b0;
            req_compl_with_data_o <= 1'b0;
            a_done_o              <= ~grant_b_o;
            b_done_o              <= grant_b_o;
          end else begin
            wd <= wd + CNT_W'(1);
          end
        end
        RELEASE: begin
          state    <= IDLE;
          a_done_o <= 1'b0;
          b_done_o <= 1'b0;
        end
        default: begin
          state                 <= IDLE;
          req_compl_o           <= 1'b0;
          req_compl_with_data_o <= 1'b0;
          a_done_o              <= 1'b0;
          b_done_o              <= 1'b0;
        end
      endcase

      // A new error event in the same cycle as a clear wins over the clear.
      if (timeout_evt) begin
        err_timeout_o <= 1'b1;
        timeout_cnt_o <= clr_err_i ? CNT_W'(1) : sat_inc(timeout_cnt_o);
      end else if (clr_err_i) begin
        err_timeout_o <= 1'b0;
        timeout_cnt_o <= '0;
      end else begin
        err_timeout_o <= err_timeout_o;
      end

      if (spurious_evt) begin
        err_spurious_o <= 1'b1;
      end else if (clr_err_i) begin
        err_spurious_o <= 1'b0;
      end else begin
        err_spurious_o <= err_spurious_o;
      end
    end
  end

  assign req_tc_o   = hdr_lat.tc;
  assign req_td_o   = hdr_lat.td;
  assign req_ep_o   = hdr_lat.ep;
  assign req_attr_o = hdr_lat.attr;
  assign req_len_o  = hdr_lat.len;
  assign req_rid_o  = hdr_lat.rid;
  assign req_tag_o  = hdr_lat.tag;
  assign req_be_o   = hdr_lat.be;
  assign req_addr_o = hdr_lat.addr;

endmodule

// File: tb/tb_compl_req_arbiter.sv
// Scoreboard bench for compl_req_arbiter: directed stimulus pushes expected grants and
// done pulses; a negedge monitor pops and compares them as the DUT presents them.
module tb_compl_req_arbiter;

  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic rst, a_req, a_wd, b_req, b_wd, compl_done, clr_err;
  logic [55:0] a_hdr, b_hdr;
  logic a_done, b_done, req_compl, req_wd, grant_b, err_to, err_sp;
  logic [2:0] tc; logic td, ep; logic [1:0] attr; logic [9:0] len;
  logic [15:0] rid; logic [7:0] tag, be; logic [6:0] addr;
  logic [CNT_W-1:0] to_cnt;

  always #5 clk = ~clk;

  compl_req_arbiter #(.TIMEOUT_CYCLES(16), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .a_req_i(a_req), .a_with_data_i(a_wd), .a_hdr_i(a_hdr), .a_done_o(a_done),
    .b_req_i(b_req), .b_with_data_i(b_wd), .b_hdr_i(b_hdr), .b_done_o(b_done),
    .req_compl_o(req_compl), .req_compl_with_data_o(req_wd), .compl_done_i(compl_done),
    .req_tc_o(tc), .req_td_o(td), .req_ep_o(ep), .req_attr_o(attr), .req_len_o(len),
    .req_rid_o(rid), .req_tag_o(tag), .req_be_o(be), .req_addr_o(addr),
    .grant_b_o(grant_b), .err_timeout_o(err_to), .err_spurious_o(err_sp),
    .timeout_cnt_o(to_cnt), .clr_err_i(clr_err)
  );

  wire [55:0] out_hdr = {tc, td, ep, attr, len, rid, tag, be, addr};

  typedef struct { bit gb; bit wdat; logic [55:0] hdr; } grant_t;
  grant_t gq[$];
  bit     dq[$];
  grant_t cur;
  logic   prev_rc = 1'b0;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [55:0] mk_hdr(input logic [2:0] t, input logic [9:0] l,
                                         input logic [15:0] r, input logic [7:0] g,
                                         input logic [7:0] b, input logic [6:0] ad);
    mk_hdr = {t, 1'b0, 1'b0, 2'b00, l, r, g, b, ad};
  endfunction

  task automatic push_grant(input bit gb, input bit wdat, input logic [55:0] h);
    grant_t g;
    g.gb = gb; g.wdat = wdat; g.hdr = h;
    gq.push_back(g);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: grant rises and done pulses are popped from the scoreboard queues.
  always @(negedge clk) begin
    if (!rst) begin
      if (req_compl && !prev_rc) begin
        if (gq.size() == 0) begin
          chk("unexpected_grant", 64'd1, 64'd0);
        end else begin
          cur = gq.pop_front();
          chk("grant_owner", 64'(grant_b), 64'(cur.gb));
          chk("grant_with_data", 64'(req_wd), 64'(cur.wdat));
          chk("grant_hdr", 64'(out_hdr), 64'(cur.hdr));
        end
      end else if (req_compl && prev_rc) begin
        chk("busy_hdr_stable", 64'(out_hdr), 64'(cur.hdr));
        chk("busy_wd_stable", 64'(req_wd), 64'(cur.wdat));
      end
      if (a_done || b_done) begin
        if (dq.size() == 0) begin
          chk("unexpected_done", {62'd0, a_done, b_done}, 64'd0);
        end else begin
          chk("done_owner", {62'd0, a_done, b_done}, dq.pop_front() ? 64'd1 : 64'd2);
        end
      end
    end
    prev_rc = req_compl;
  end

  initial begin
    logic [55:0] h_a1, h_a2, h_b1, h_b2;
    rst = 1'b1; a_req = 1'b0; a_wd = 1'b0; b_req = 1'b0; b_wd = 1'b0;
    compl_done = 1'b0; clr_err = 1'b0; a_hdr = '0; b_hdr = '0;
    tick(2);
    chk("rst_req_compl", 64'(req_compl), 64'd0);
    chk("rst_grant_b", 64'(grant_b), 64'd0);
    chk("rst_flags", {62'd0, err_to, err_sp}, 64'd0);
    chk("rst_cnt", 64'(to_cnt), 64'd0);
    chk("rst_hdr", 64'(out_hdr), 64'd0);
    rst = 1'b0;

    // A only, CplD, done 5 cycles after the grant
    h_a1 = mk_hdr(3'd0, 10'd1, 16'h0100, 8'h05, 8'h0F, 7'h00);
    a_hdr = h_a1; a_wd = 1'b1; a_req = 1'b1;
    push_grant(1'b0, 1'b1, h_a1);
    tick(1);
    chk("t1_latency", 64'(req_compl), 64'd1);
    a_hdr = 56'hFF_FFFF_FFFF_FFFF;
    for (int k = 0; k < 4; k++) begin
      tick(1);
      chk("t1_held", 64'(req_compl), 64'd1);
    end
    dq.push_back(1'b0);
    compl_done = 1'b1;
    tick(1);
    compl_done = 1'b0;
    chk("t1_a_done", 64'(a_done), 64'd1);
    chk("t1_req_drop", {62'd0, req_compl, req_wd}, 64'd0);
    a_req = 1'b0;
    tick(1);
    chk("t1_done_single", 64'(a_done), 64'd0);
    chk("t1_fields_hold", 64'(tag), 64'h05);

    // Simultaneous A/B after reset: A, B, A, B with a two-cycle done-to-request gap
    rst = 1'b1; tick(1); rst = 1'b0;
    h_a1 = mk_hdr(3'd1, 10'd4, 16'hA001, 8'h11, 8'hFF, 7'h04);
    h_b1 = mk_hdr(3'd2, 10'd8, 16'hB001, 8'h21, 8'hF0, 7'h08);
    h_a2 = mk_hdr(3'd3, 10'd2, 16'hA002, 8'h12, 8'h0F, 7'h0C);
    h_b2 = mk_hdr(3'd4, 10'd1, 16'hB002, 8'h22, 8'h01, 7'h10);
    a_hdr = h_a1; b_hdr = h_b1; a_wd = 1'b0; b_wd = 1'b1;
    push_grant(1'b0, 1'b0, h_a1); push_grant(1'b1, 1'b1, h_b1);
    push_grant(1'b0, 1'b0, h_a2); push_grant(1'b1, 1'b1, h_b2);
    a_req = 1'b1; b_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      chk("t2_grant", 64'(req_compl), 64'd1);
      chk("t2_owner", 64'(grant_b), 64'(i % 2));
      tick(3);
      dq.push_back(i % 2 == 1);
      compl_done = 1'b1;
      tick(1);
      compl_done = 1'b0;
      chk("t2_done", {62'd0, a_done, b_done}, (i % 2 == 1) ? 64'd1 : 64'd2);
      chk("t2_release", 64'(req_compl), 64'd0);
      if (i % 2 == 1) b_req = 1'b0; else a_req = 1'b0;
      if (i == 0) a_hdr = h_a2;
      if (i == 1) b_hdr = h_b2;
      if (i == 3) a_req = 1'b0;
      tick(1);
      chk("t2_gap", 64'(req_compl), 64'd0);
      if (i < 3) begin
        if (i % 2 == 1) b_req = 1'b1; else a_req = 1'b1;
      end
    end

    // Watchdog: 16 BUSY cycles then forced release; B then served normally
    h_a1 = mk_hdr(3'd5, 10'd16, 16'hA003, 8'h13, 8'h3C, 7'h14);
    h_b1 = mk_hdr(3'd6, 10'd32, 16'hB003, 8'h23, 8'hC3, 7'h18);
    a_hdr = h_a1; b_hdr = h_b1; a_wd = 1'b1; b_wd = 1'b0;
    push_grant(1'b0, 1'b1, h_a1); push_grant(1'b1, 1'b0, h_b1);
    dq.push_back(1'b0);
    a_req = 1'b1; b_req = 1'b1;
    tick(1);
    for (int k = 0; k < 16; k++) begin
      chk("t3_busy", 64'(req_compl), 64'd1);
      tick(1);
    end
    chk("t3_forced_done", 64'(a_done), 64'd1);
    chk("t3_req_drop", 64'(req_compl), 64'd0);
    chk("t3_err_timeout", 64'(err_to), 64'd1);
    chk("t3_cnt", 64'(to_cnt), 64'd1);
    a_req = 1'b0;
    tick(1);
    chk("t3_sticky", 64'(err_to), 64'd1);
    tick(1);
    chk("t3_b_grant", {62'd0, req_compl, grant_b}, 64'd3);
    tick(2);
    dq.push_back(1'b1);
    compl_done = 1'b1;
    tick(1);
    compl_done = 1'b0;
    chk("t3_b_done", 64'(b_done), 64'd1);
    chk("t3_cnt_kept", 64'(to_cnt), 64'd1);
    b_req = 1'b0;
    tick(1);

    // Spurious done in IDLE, clear, and clear colliding with a new error
    compl_done = 1'b1;
    tick(1);
    compl_done = 1'b0;
    chk("t5_spurious", 64'(err_sp), 64'd1);
    chk("t5_idle", 64'(req_compl), 64'd0);
    chk("t5_timeout_kept", 64'(err_to), 64'd1);
    tick(1);
    chk("t5_still_idle", 64'(req_compl), 64'd0);
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    chk("t5_clr_flags", {62'd0, err_to, err_sp}, 64'd0);
    chk("t5_clr_cnt", 64'(to_cnt), 64'd0);
    compl_done = 1'b1; clr_err = 1'b1;
    tick(1);
    compl_done = 1'b0; clr_err = 1'b0;
    chk("t5_err_wins", 64'(err_sp), 64'd1);
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    chk("t5_clr_again", 64'(err_sp), 64'd0);

    // Completion on the exact watchdog expiry cycle
    h_a1 = mk_hdr(3'd7, 10'd3, 16'hA004, 8'h14, 8'h5A, 7'h1C);
    a_hdr = h_a1; a_wd = 1'b0;
    push_grant(1'b0, 1'b0, h_a1);
    a_req = 1'b1;
    tick(1);
    chk("t4_grant", 64'(req_compl), 64'd1);
    tick(15);
    chk("t4_still_busy", 64'(req_compl), 64'd1);
    dq.push_back(1'b0);
    compl_done = 1'b1;
    tick(1);
    compl_done = 1'b0;
    chk("t4_done", 64'(a_done), 64'd1);
    chk("t4_no_timeout", 64'(err_to), 64'd0);
    chk("t4_cnt", 64'(to_cnt), 64'd0);
    a_req = 1'b0;
    tick(1);

    // Reset mid-BUSY aborts without a done; pointer returns to favour A
    h_a1 = mk_hdr(3'd1, 10'd5, 16'hA005, 8'h15, 8'h77, 7'h20);
    h_a2 = mk_hdr(3'd2, 10'd6, 16'hA006, 8'h16, 8'h88, 7'h24);
    h_b1 = mk_hdr(3'd3, 10'd7, 16'hB005, 8'h25, 8'h99, 7'h28);
    a_hdr = h_a1; a_wd = 1'b1;
    push_grant(1'b0, 1'b1, h_a1);
    a_req = 1'b1;
    tick(1);
    chk("t6_grant", 64'(req_compl), 64'd1);
    tick(2);
    rst = 1'b1;
    tick(1);
    chk("t6_abort", 64'(req_compl), 64'd0);
    chk("t6_no_done", {62'd0, a_done, b_done}, 64'd0);
    chk("t6_grant_b_rst", 64'(grant_b), 64'd0);
    rst = 1'b0;
    a_hdr = h_a2; b_hdr = h_b1; b_wd = 1'b0; b_req = 1'b1;
    push_grant(1'b0, 1'b1, h_a2); push_grant(1'b1, 1'b0, h_b1);
    tick(1);
    chk("t6_a_first", {62'd0, req_compl, grant_b}, 64'd2);
    tick(2);
    dq.push_back(1'b0);
    compl_done = 1'b1;
    tick(1);
    compl_done = 1'b0;
    chk("t6_a_done", 64'(a_done), 64'd1);
    a_req = 1'b0;
    tick(1);
    tick(1);
    chk("t6_b_next", {62'd0, req_compl, grant_b}, 64'd3);
    dq.push_back(1'b1);
    compl_done = 1'b1;
    tick(1);
    compl_done = 1'b0;
    chk("t6_b_done", 64'(b_done), 64'd1);
    b_req = 1'b0;
    tick(3);
    #5;
    chk("grant_queue_empty", 64'(gq.size()), 64'd0);
    chk("done_queue_empty", 64'(dq.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
